// File: rtl/l1ci_ctrl_if.sv
// l1ci_ctrl_if: AXI4 read address/data channels between the
// I-cache controller (master) and the CPU wrapper port (slave).
interface l1ci_ctrl_if;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arlen, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/l1ci_ctrl.sv
// l1ci_ctrl: L1 I-cache control FSM between the fetch port,
// the L1C_inst tag/data arrays and an AXI4 read-burst master.
module l1ci_ctrl #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic [31:0] RW_addr_C,
    output logic [31:0] write_data_C,
    output logic        WEB_C,
    output logic        read_req_hit,
    output logic        read_req_miss_last,
    input  logic        hit,
    input  logic [31:0] read_data_C,
    l1ci_ctrl_if.master axi
);
    typedef enum logic [2:0] {
        IDLE,
        CHK,
        AR,
        R,
        FIN
    } state_t;

    state_t      state;
    logic [31:0] addr_reg;
    logic [1:0]  beat_cnt;
    logic [31:0] word_reg;
    logic        rresp_unused;

    // Response code is deliberately ignored: every beat is written.
    assign rresp_unused = ^axi.rresp;

    assign axi.arlen   = 4'(LINE_WORDS - 1);
    assign axi.arburst = 2'b01;
    assign axi.araddr  = {addr_reg[31:4], 4'b0000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_reg <= '0;
            beat_cnt <= '0;
            word_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (core_req) begin
                        addr_reg <= core_addr;
                        state    <= CHK;
                    end
                end
                CHK: state <= hit ? IDLE : AR;
                AR: begin
                    if (axi.arready) begin
                        beat_cnt <= '0;
                        state    <= R;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == addr_reg[3:2])
                            word_reg <= axi.rdata;
                        // Only rlast ends the burst.
                        if (axi.rlast)
                            state <= FIN;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        core_out           = '0;
        core_wait          = 1'b0;
        RW_addr_C          = addr_reg;
        write_data_C       = '0;
        WEB_C              = 1'b1;
        read_req_hit       = 1'b0;
        read_req_miss_last = 1'b0;
        axi.arvalid        = 1'b0;
        axi.rready         = 1'b0;
        unique case (state)
            IDLE: begin
                core_wait = core_req;
                RW_addr_C = core_addr;
            end
            CHK: begin
                if (hit) begin
                    core_out     = read_data_C;
                    read_req_hit = 1'b1;
                end else begin
                    core_wait = 1'b1;
                end
            end
            AR: begin
                core_wait   = 1'b1;
                axi.arvalid = 1'b1;
            end
            R: begin
                core_wait    = 1'b1;
                axi.rready   = 1'b1;
                RW_addr_C    = {addr_reg[31:4], beat_cnt, 2'b00};
                write_data_C = axi.rdata;
                WEB_C        = ~axi.rvalid;
            end
            FIN: begin
                // Pulse after the final write keeps the whole line in one way.
                read_req_miss_last = 1'b1;
                core_out           = word_reg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l1ci_ctrl.sv
// tb_l1ci_ctrl: scoreboard bench for l1ci_ctrl with a 2-way
// array model and a reactive AXI read slave.
module tb_l1ci_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_out;
    logic        core_wait;
    logic [31:0] RW_addr_C;
    logic [31:0] write_data_C;
    logic        WEB_C;
    logic        read_req_hit;
    logic        read_req_miss_last;
    logic        hit;
    logic [31:0] read_data_C;

    l1ci_ctrl_if axi();

    l1ci_ctrl #(.LINE_WORDS(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .core_req           (core_req),
        .core_addr          (core_addr),
        .core_out           (core_out),
        .core_wait          (core_wait),
        .RW_addr_C          (RW_addr_C),
        .write_data_C       (write_data_C),
        .WEB_C              (WEB_C),
        .read_req_hit       (read_req_hit),
        .read_req_miss_last (read_req_miss_last),
        .hit                (hit),
        .read_data_C        (read_data_C),
        .axi                (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          is_hit;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t        rspq[$];
    logic [31:0] arq[$];
    wr_t         wq[$];

    int checks = 0;
    int errors = 0;
    int n_ar = 0;
    int n_wr = 0;
    int n_hitp = 0;
    int n_missp = 0;
    int ar_delay = 0;
    int gap_beat = 99;
    int gap_len = 0;
    int last_cyc = 0;
    logic [31:0] beat_base = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Array model: 64 sets x 2 ways x 4 words, one victim bit per set
    logic [21:0] tag_m [2][64];
    logic        vld_m [2][64];
    logic [31:0] dat_m [2][64][4];
    logic        lru_m [64];
    logic        way_m;
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [1:0]  wd;
    logic        h0, h1;

    assign idx = RW_addr_C[9:4];
    assign tg  = RW_addr_C[31:10];
    assign wd  = RW_addr_C[3:2];
    assign h0  = vld_m[0][idx] && (tag_m[0][idx] == tg);
    assign h1  = vld_m[1][idx] && (tag_m[1][idx] == tg);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 64; s++) begin
                vld_m[0][s] <= 1'b0;
                vld_m[1][s] <= 1'b0;
                lru_m[s]    <= 1'b0;
            end
            hit         <= 1'b0;
            read_data_C <= '0;
            way_m       <= 1'b0;
        end else begin
            hit         <= h0 | h1;
            read_data_C <= h0 ? dat_m[0][idx][wd] :
                           h1 ? dat_m[1][idx][wd] : 32'h0;
            way_m       <= h1;
            if (!WEB_C) begin
                vld_m[lru_m[idx]][idx]     <= 1'b1;
                tag_m[lru_m[idx]][idx]     <= tg;
                dat_m[lru_m[idx]][idx][wd] <= write_data_C;
            end
            if (read_req_miss_last)
                lru_m[idx] <= ~lru_m[idx];
            if (read_req_hit)
                lru_m[idx] <= ~way_m;
        end
    end

    // AXI read slave
    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        forever begin
            @(negedge clk);
            if (axi.arvalid && rst) begin
                repeat (ar_delay) @(posedge clk);
                @(posedge clk);
                #1 axi.arready = 1'b1;
                @(posedge clk);
                #1 axi.arready = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    if (b == gap_beat) begin
                        axi.rvalid = 1'b0;
                        for (int g = 0; g < gap_len; g++) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    axi.rvalid = 1'b1;
                    axi.rdata  = beat_base + 32'(b);
                    axi.rlast  = (b == 3);
                    axi.rresp  = 2'(b);
                    @(posedge clk or negedge rst);
                    if (!rst) break;
                    #1;
                end
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
            end
        end
    end

    // Monitors
    rsp_t        e_rsp;
    wr_t         e_wr;
    logic [31:0] e_ar;

    always @(negedge clk) begin
        if (rst) begin
            if (core_req && !core_wait) begin
                if (rspq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %h expected none",
                             core_out);
                end else begin
                    e_rsp = rspq.pop_front();
                    check("core_out", core_out, e_rsp.data);
                    check("hit_pulse", 32'(read_req_hit),
                          32'(e_rsp.is_hit));
                    check("fill_pulse", 32'(read_req_miss_last),
                          32'(!e_rsp.is_hit));
                end
            end
            if (read_req_hit) n_hitp++;
            if (read_req_miss_last) n_missp++;
            if (axi.arvalid && axi.arready) begin
                n_ar++;
                if (arq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ar: got %h expected none",
                             axi.araddr);
                end else begin
                    e_ar = arq.pop_front();
                    check("araddr", axi.araddr, e_ar);
                    check("arlen", 32'(axi.arlen), 32'd3);
                    check("arburst", 32'(axi.arburst), 32'd1);
                end
            end
            if (!WEB_C) begin
                n_wr++;
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got %h expected none",
                             RW_addr_C);
                end else begin
                    e_wr = wq.pop_front();
                    check("wr_addr", RW_addr_C, e_wr.addr);
                    check("wr_data", write_data_C, e_wr.data);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                         input bit is_hit, input logic [31:0] base);
        int   cyc;
        wr_t  w;
        rsp_t r;
        r.data   = exp;
        r.is_hit = is_hit;
        rspq.push_back(r);
        if (!is_hit) begin
            beat_base = base;
            arq.push_back({a[31:4], 4'b0000});
            for (int b = 0; b < 4; b++) begin
                w.addr = {a[31:4], 2'(b), 2'b00};
                w.data = base + 32'(b);
                wq.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = a;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (core_wait && cyc < 300);
        if (core_wait) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: got wait after %0d cycles expected done",
                     cyc);
        end
        last_cyc = cyc;
        @(posedge clk);
        #1 core_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   base_ar;
        int   base_wr;
        wr_t  w;
        core_req  = 1'b1;
        core_addr = '0;

        // Reset held with a pending request
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 32'(core_wait), 32'd1);
        check("rst_arvalid", 32'(axi.arvalid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_arvalid", 32'(axi.arvalid), 32'd0);
        check("rel_rready", 32'(axi.rready), 32'd0);
        check("rel_web", 32'(WEB_C), 32'd1);
        check("rel_wait", 32'(core_wait), 32'd1);
        #1 core_req = 1'b0;
        #1 check("idle_wait", 32'(core_wait), 32'd0);

        // Cold miss with delayed arready
        ar_delay = 2;
        fetch(32'h0000_1234, 32'hA1, 1'b0, 32'hA0);
        check("cold_missp", 32'(n_missp), 32'd1);

        // Hit in the freshly filled line
        base_ar = n_ar;
        fetch(32'h0000_1238, 32'hA2, 1'b1, 32'h0);
        check("hit_latency", 32'(last_cyc), 32'd2);
        check("hit_no_ar", 32'(n_ar), 32'(base_ar));

        // Invalidate arrays, then gapped refill of the same line
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        ar_delay = 0;
        gap_beat = 2;
        gap_len  = 3;
        base_wr  = n_wr;
        fetch(32'h0000_1234, 32'hB1, 1'b0, 32'hB0);
        check("gap_writes", 32'(n_wr - base_wr), 32'd4);
        gap_beat = 99;
        gap_len  = 0;

        // Reset after two beats of a burst
        beat_base = 32'hC0;
        arq.push_back(32'h0000_5670);
        w.addr = 32'h0000_5670;
        w.data = 32'hC0;
        wq.push_back(w);
        w.addr = 32'h0000_5674;
        w.data = 32'hC1;
        wq.push_back(w);
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = 32'h0000_5678;
        cyc = 0;
        while (wq.size() != 0 && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("abort_reach", 32'(wq.size()), 32'd0);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        core_req = 1'b0;
        #1;
        check("abort_rready", 32'(axi.rready), 32'd0);
        check("abort_arvalid", 32'(axi.arvalid), 32'd0);
        check("abort_web", 32'(WEB_C), 32'd1);
        check("abort_wait", 32'(core_wait), 32'd0);
        check("abort_ar", 32'(arq.size()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        base_ar = n_ar;
        fetch(32'h0000_5678, 32'hD2, 1'b0, 32'hD0);
        check("refetch_ar", 32'(n_ar - base_ar), 32'd1);

        // Two tags on one set, then both hit
        fetch(32'h0000_2040, 32'hE0, 1'b0, 32'hE0);
        fetch(32'h0000_6044, 32'hF1, 1'b0, 32'hF0);
        base_ar = n_ar;
        fetch(32'h0000_2048, 32'hE2, 1'b1, 32'h0);
        fetch(32'h0000_604C, 32'hF3, 1'b1, 32'h0);
        check("set_hits_no_ar", 32'(n_ar), 32'(base_ar));

        repeat (3) @(posedge clk);
        #1;
        check("rsp_left", 32'(rspq.size()), 32'd0);
        check("ar_left", 32'(arq.size()), 32'd0);
        check("wr_left", 32'(wq.size()), 32'd0);
        check("miss_pulses", 32'(n_missp), 32'd5);
        check("hit_pulses", 32'(n_hitp), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
